// File: rtl/collision_scheduler.sv
// Time-multiplexes one combinational collision unit between two players per frame,
// committing both results together so partial results are never visible.
module collision_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [31:0] pos1,
    input  logic [31:0] pos2,
    input  logic [31:0] size1,
    input  logic [31:0] size2,
    input  logic [3:0]  coll,
    input  logic        clr_overrun,
    output logic [31:0] player_pos,
    output logic [31:0] player_size,
    output logic [31:0] collis1,
    output logic [31:0] collis2,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, EVAL1, EVAL2, COMMIT} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  res1;
    logic [3:0]  res2;
    logic [31:0] pos2_snap;

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            res1        <= '0;
            res2        <= '0;
            pos2_snap   <= '0;
            player_pos  <= '0;
            player_size <= '0;
            collis1     <= '0;
            collis2     <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;

            // A tick while busy is dropped but remembered; set beats clear.
            if (frame_tick && state != IDLE)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (frame_tick) begin
                        pos2_snap   <= pos2;
                        player_pos  <= pos1;
                        player_size <= size1;
                        cnt         <= RELOAD;
                        state       <= EVAL1;
                    end
                end
                EVAL1: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res1        <= coll;
                        player_pos  <= pos2_snap;
                        player_size <= size2;
                        cnt         <= RELOAD;
                        state       <= EVAL2;
                    end
                end
                EVAL2: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res2  <= coll;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    collis1 <= {28'b0, res1};
                    collis2 <= {28'b0, res2};
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed frame results, monitors pop and
// compare them on each done pulse (SETTLE_CYCLES=1 and SETTLE_CYCLES=3 instances).
module tb_collision_scheduler;

    logic        clock = 1'b0;
    logic        reset, reset3;
    logic        frame_tick, tick3, clr_overrun, clr3;
    logic [31:0] pos1, pos2, size1, size2;
    logic [3:0]  coll, coll3;
    logic [31:0] player_pos, player_size, collis1, collis2;
    logic        busy, done, overrun;
    logic [31:0] player_pos_3, player_size_3, collis1_3, collis2_3;
    logic        busy_3, done_3, overrun_3;

    typedef struct {
        logic [3:0] c1;
        logic [3:0] c2;
        int         at;
    } exp_t;

    exp_t q[$];
    exp_t q3[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in for the shared collision unit; two fixed operands give fixed answers.
    function automatic logic [3:0] coll_fn(input logic [31:0] p, input logic [31:0] s);
        case (p)
            32'h016000FA: return 4'b0100;
            32'h00200030: return 4'b0001;
            default:      return p[3:0] ^ s[3:0] ^ p[19:16];
        endcase
    endfunction

    assign coll  = coll_fn(player_pos, player_size);
    assign coll3 = coll_fn(player_pos_3, player_size_3);

    collision_scheduler #(.SETTLE_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .pos1(pos1), .pos2(pos2), .size1(size1), .size2(size2),
        .coll(coll), .clr_overrun(clr_overrun),
        .player_pos(player_pos), .player_size(player_size),
        .collis1(collis1), .collis2(collis2),
        .busy(busy), .done(done), .overrun(overrun)
    );

    collision_scheduler #(.SETTLE_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset3), .frame_tick(tick3),
        .pos1(pos1), .pos2(pos2), .size1(size1), .size2(size2),
        .coll(coll3), .clr_overrun(clr3),
        .player_pos(player_pos_3), .player_size(player_size_3),
        .collis1(collis1_3), .collis2(collis2_3),
        .busy(busy_3), .done(done_3), .overrun(overrun_3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("collis1", collis1, {28'b0, e.c1});
                check("collis2", collis2, {28'b0, e.c2});
                check("done_latency", 32'(cyc), 32'(e.at));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset3 && done_3) begin
            if (q3.size() == 0) begin
                check("unexpected_done3", 32'(done_3), 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("collis1_s3", collis1_3, {28'b0, e.c1});
                check("collis2_s3", collis2_3, {28'b0, e.c2});
                check("done_latency_s3", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic frame_start(input logic [31:0] p1, input logic [31:0] s1,
                               input logic [31:0] p2, input logic [31:0] s2,
                               input logic [3:0] c1, input logic [3:0] c2);
        @(negedge clock);
        pos1 = p1; size1 = s1; pos2 = p2; size2 = s2;
        frame_tick = 1'b1;
        @(posedge clock);
        #1;
        q.push_back('{c1: c1, c2: c2, at: cyc + 3});
        frame_tick = 1'b0;
        check("load_pos", player_pos, p1);
        check("load_size", player_size, s1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q3.size() != 0) && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("pending_results", 32'(q.size() + q3.size()), 32'd0);
    endtask

    task automatic clear_overrun();
        @(negedge clock);
        clr_overrun = 1'b1;
        @(negedge clock);
        clr_overrun = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int dc;
        reset = 1'b1; reset3 = 1'b1;
        frame_tick = 1'b0; tick3 = 1'b0; clr_overrun = 1'b0; clr3 = 1'b0;
        pos1 = '0; pos2 = '0; size1 = '0; size2 = '0;
        #1;
        check("rst_player_pos", player_pos, 32'd0);
        check("rst_collis1", collis1, 32'd0);
        check("rst_collis2", collis2, 32'd0);
        check("rst_busy_done_ovr", {29'b0, busy, done, overrun}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0; reset3 = 1'b0;

        // Basic frame, SETTLE=1
        frame_start(32'h016000FA, 32'h0085007D, 32'h00200030, 32'h00100010, 4'h4, 4'h1);
        check("busy_eval1", 32'(busy), 32'd1);
        @(negedge clock);
        @(negedge clock);
        check("pos_switch", player_pos, 32'h00200030);
        drain();
        repeat (3) @(negedge clock);
        check("collis1_hold", collis1, 32'h4);
        check("player_pos_hold", player_pos, 32'h00200030);

        // SETTLE=3: size2 changes in EVAL1 and must be the one used for P2
        @(negedge clock);
        pos1 = 32'h016000FA; size1 = '0; pos2 = 32'h00300031; size2 = '0;
        tick3 = 1'b1;
        @(posedge clock);
        #1;
        q3.push_back('{c1: 4'h4, c2: 4'h5, at: cyc + 7});
        tick3 = 1'b0;
        check("s3_load_pos", player_pos_3, 32'h016000FA);
        @(negedge clock);
        @(negedge clock);
        size2 = 32'h00000004;
        @(negedge clock);
        check("s3_pos_edge2", player_pos_3, 32'h016000FA);
        @(negedge clock);
        check("s3_pos_edge3", player_pos_3, 32'h00300031);
        check("s3_size_edge3", player_size_3, 32'h00000004);
        drain();

        // Tick during EVAL2 sets overrun, frame unaffected
        frame_start(32'h00030008, 32'h00000001, 32'h0007000C, 32'h00000005, 4'hA, 4'hE);
        @(negedge clock);
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        drain();
        clear_overrun();
        check("overrun_clr", 32'(overrun), 32'd0);

        // Overrun and clear on the same edge: set wins
        frame_start(32'h00030008, 32'h00000001, 32'h0007000C, 32'h00000005, 4'hA, 4'hE);
        @(negedge clock);
        frame_tick = 1'b1;
        clr_overrun = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        clr_overrun = 1'b0;
        check("overrun_set_wins", 32'(overrun), 32'd1);
        drain();
        clear_overrun();

        // Inputs changing after acceptance must not leak into the frame
        frame_start(32'h00120034, 32'h00050009, 32'h00450067, 32'h0003000B, 4'hF, 4'h9);
        pos1 = ~32'h00120034;
        @(negedge clock);
        pos2 = 32'h00450067 ^ 32'h00050007;
        drain();

        // frame_tick held for 20 edges: accepts every 4th edge
        @(negedge clock);
        pos1 = 32'h016000FA; size1 = 32'h0085007D; pos2 = 32'h00200030; size2 = 32'h00100010;
        frame_tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (i % 4 == 0) q.push_back('{c1: 4'h4, c2: 4'h1, at: cyc + 3});
        end
        @(negedge clock);
        frame_tick = 1'b0;
        check("held_overrun", 32'(overrun), 32'd1);
        drain();

        // Asynchronous reset in EVAL2 aborts the frame
        frame_start(32'h00120034, 32'h00050009, 32'h00450067, 32'h0003000B, 4'hF, 4'h9);
        @(negedge clock);
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("arst_player_pos", player_pos, 32'd0);
        check("arst_player_size", player_size, 32'd0);
        check("arst_collis1", collis1, 32'd0);
        check("arst_collis2", collis2, 32'd0);
        check("arst_busy_done_ovr", {29'b0, busy, done, overrun}, 32'd0);
        q.delete();
        dc = done_cnt;
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("no_done_after_abort", 32'(done_cnt), 32'(dc));

        frame_start(32'h000A0005, 32'h00000000, 32'h00000000, 32'h00000006, 4'hF, 4'h6);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
